// File: rtl/write_row_sequencer.sv
// Row-by-row configuration sequencer for the output row writer.
// Optional wait-state watchdog enabled by defining WRSEQ_TIMEOUT_EN.
module write_row_sequencer #(
    parameter int unsigned X_MAC        = 4,
    parameter int unsigned ADDR_LEN     = 13,
    parameter int unsigned MAX_LINE_LEN = 10,
    parameter int unsigned ROW_CNT_LEN  = 10,
    parameter int unsigned TIMEOUT_CYC  = 1023
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [ADDR_LEN*X_MAC-1:0] cfg_base_addr,
    input  logic [ADDR_LEN-1:0]       cfg_row_stride,
    input  logic [ROW_CNT_LEN-1:0]    cfg_rows,
    input  logic [MAX_LINE_LEN-1:0]   cfg_linelen,
    input  logic [1:0]                cfg_valid_mac,
    input  logic                      cfg_pooled,
    input  logic [4:0]                cfg_shift_len,
    input  logic                      wr_idle,
    output logic                      conf_input,
    output logic [ADDR_LEN*X_MAC-1:0] st_addr,
    output logic [MAX_LINE_LEN-1:0]   linelen,
    output logic [1:0]                valid_mac,
    output logic                      pooled,
    output logic [4:0]                shift_len,
    output logic [ROW_CNT_LEN-1:0]    row_idx,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int unsigned ST_W = ADDR_LEN * X_MAC;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_START,
        S_WAIT_DONE,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_LEN-1:0]     stride_q, stride_nxt;
    logic [ROW_CNT_LEN-1:0]  rows_q, rows_nxt;
    logic [ST_W-1:0]         st_addr_nxt;
    logic [MAX_LINE_LEN-1:0] linelen_nxt;
    logic [1:0]              valid_mac_nxt;
    logic                    pooled_nxt;
    logic [4:0]              shift_len_nxt;
    logic [ROW_CNT_LEN-1:0]  row_idx_nxt;
    logic                    err_nxt;
    logic                    wd_expired;

`ifdef WRSEQ_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_cnt;

    // Cycles spent in the current wait state; cleared on every state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (state_nxt != state) begin
            wd_cnt <= '0;
        end else if (state == S_WAIT_START || state == S_WAIT_DONE) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout;

    assign unused_timeout = |32'(TIMEOUT_CYC);
    assign wd_expired     = 1'b0;
`endif

    // Next-state and next-output logic; registered outputs follow state_nxt.
    always_comb begin
        state_nxt     = state;
        stride_nxt    = stride_q;
        rows_nxt      = rows_q;
        st_addr_nxt   = st_addr;
        linelen_nxt   = linelen;
        valid_mac_nxt = valid_mac;
        pooled_nxt    = pooled;
        shift_len_nxt = shift_len;
        row_idx_nxt   = row_idx;
        err_nxt       = err;

        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        err_nxt = 1'b0;
                        if (cfg_rows != '0) begin
                            stride_nxt    = cfg_row_stride;
                            rows_nxt      = cfg_rows;
                            st_addr_nxt   = cfg_base_addr;
                            linelen_nxt   = cfg_linelen;
                            valid_mac_nxt = cfg_valid_mac;
                            pooled_nxt    = cfg_pooled;
                            shift_len_nxt = cfg_shift_len;
                            row_idx_nxt   = '0;
                            state_nxt     = S_ISSUE;
                        end else begin
                            state_nxt = S_DONE;
                        end
                    end
                end
                S_ISSUE: state_nxt = S_WAIT_START;
                S_WAIT_START: begin
                    if (!wr_idle) begin
                        state_nxt = S_WAIT_DONE;
                    end else if (wd_expired) begin
                        state_nxt = S_IDLE;
                        err_nxt   = 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (wr_idle) begin
                        if (row_idx == rows_q - ROW_CNT_LEN'(1)) begin
                            state_nxt = S_DONE;
                        end else begin
                            row_idx_nxt = row_idx + ROW_CNT_LEN'(1);
                            // Each bank wraps independently; no carry across banks.
                            for (int unsigned j = 0; j < X_MAC; j++) begin
                                st_addr_nxt[j*ADDR_LEN +: ADDR_LEN] =
                                    st_addr[j*ADDR_LEN +: ADDR_LEN] + stride_q;
                            end
                            state_nxt = S_ISSUE;
                        end
                    end else if (wd_expired) begin
                        state_nxt = S_IDLE;
                        err_nxt   = 1'b1;
                    end
                end
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            stride_q   <= '0;
            rows_q     <= '0;
            st_addr    <= '0;
            linelen    <= '0;
            valid_mac  <= '0;
            pooled     <= 1'b0;
            shift_len  <= '0;
            row_idx    <= '0;
            err        <= 1'b0;
            conf_input <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            stride_q   <= stride_nxt;
            rows_q     <= rows_nxt;
            st_addr    <= st_addr_nxt;
            linelen    <= linelen_nxt;
            valid_mac  <= valid_mac_nxt;
            pooled     <= pooled_nxt;
            shift_len  <= shift_len_nxt;
            row_idx    <= row_idx_nxt;
            err        <= err_nxt;
            conf_input <= (state_nxt == S_ISSUE);
            busy       <= (state_nxt != S_IDLE);
            done       <= (state_nxt == S_DONE);
        end
    end

endmodule
